// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t    : controller FSM states, 2-bit encoding (RUN / MD_WAIT / MD_DONE)
//   NOP_INSTR  : instruction word loaded into a latch when it is flushed
//   REG_ZERO   : index of the hard-wired zero register (never a real hazard)
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_MD_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          REG_W     = 5;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator.
// Flags when the instruction in DX is a load whose destination is read by
// the instruction in FD. Register 0 is exempt because it is never written.
// Ports:
//   i_fd_rs, i_fd_rt         : FD source register indices
//   i_fd_uses_rs/_rt         : the matching source is actually read
//   i_dx_rd                  : DX destination register index
//   i_dx_is_load             : DX instruction is a load
//   o_hazard                 : load-use hazard present
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] i_fd_rs,
  input  logic [REG_W-1:0] i_fd_rt,
  input  logic             i_fd_uses_rs,
  input  logic             i_fd_uses_rt,
  input  logic [REG_W-1:0] i_dx_rd,
  input  logic             i_dx_is_load,
  output logic             o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = i_fd_uses_rs && (i_fd_rs == i_dx_rd);
  assign w_rt_match = i_fd_uses_rt && (i_fd_rt == i_dx_rd);
  assign o_hazard   = i_dx_is_load && (i_dx_rd != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage pipeline (FD, DX, XM, MW).
// Generates PC/latch write enables, flush/nop controls for taken branches
// and load-use stalls, and sequences a multi-cycle mul/div operation with a
// timeout that raises a sticky error flag.
//
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/flush
// performance counters (stall_cnt, flush_cnt).
//
// Ports:
//   clk, reset                  : clock; asynchronous active-low reset
//   fd_rs, fd_rt, fd_uses_rs/rt : FD source operands
//   dx_rd, dx_is_load, dx_is_md : DX destination / instruction class
//   md_ready                    : mul/div result valid
//   x_branch_taken              : taken branch/jump resolved in X
//   pc_we, fd_we, dx_we, xm_we, mw_we : write enables
//   fd_flush, dx_nop            : load nop into FD / DX
//   md_start                    : one-cycle mul/div start pulse
//   md_err                      : sticky mul/div timeout flag
//   stall_cnt, flush_cnt        : perf counters (PIPE_PERF_CNT_EN only)
//   dbg_state                   : current FSM state, for observation
//
// Handshake: md_start is a single-cycle request; md_ready is only honoured
// while waiting (MD_WAIT) and is ignored in every other state, including the
// cycle that issues md_start.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic [4:0]       dx_rd,
  input  logic             dx_is_load,
  input  logic             dx_is_md,
  input  logic             md_ready,
  input  logic             x_branch_taken,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             xm_we,
  output logic             mw_we,
  output logic             fd_flush,
  output logic             dx_nop,
  output logic             md_start,
  output logic             md_err,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       dbg_state
);

  localparam int               MDC_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [MDC_W-1:0] MDC_LAST = MDC_W'(MD_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MDC_W-1:0] r_md_cnt;
  logic [MDC_W-1:0] w_md_cnt_nxt;
  logic             r_md_err;
  logic             w_timeout;
  logic             w_load_use;

  logic w_pc_we, w_fd_we, w_dx_we, w_xm_we, w_mw_we;
  logic w_fd_flush, w_dx_nop, w_md_start;

  load_use_detect u_load_use_detect (
    .i_fd_rs      (fd_rs),
    .i_fd_rt      (fd_rt),
    .i_fd_uses_rs (fd_uses_rs),
    .i_fd_uses_rt (fd_uses_rt),
    .i_dx_rd      (dx_rd),
    .i_dx_is_load (dx_is_load),
    .o_hazard     (w_load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_md_cnt <= '0;
      r_md_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (w_timeout) r_md_err <= 1'b1;
    end
  end

  // Outputs are forced low while reset is held, so the pipeline freezes
  // immediately rather than at the next clock edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_timeout    = 1'b0;
    w_pc_we      = 1'b0;
    w_fd_we      = 1'b0;
    w_dx_we      = 1'b0;
    w_xm_we      = 1'b0;
    w_mw_we      = 1'b0;
    w_fd_flush   = 1'b0;
    w_dx_nop     = 1'b0;
    w_md_start   = 1'b0;
    if (reset) begin
      case (r_state)
        ST_RUN: begin
          w_pc_we = 1'b1;
          w_fd_we = 1'b1;
          w_dx_we = 1'b1;
          w_xm_we = 1'b1;
          w_mw_we = 1'b1;
          // A taken branch squashes FD and DX, so whatever sits in DX
          // (load or mul/div) is on the wrong path and must not act.
          if (x_branch_taken) begin
            w_fd_flush = 1'b1;
            w_dx_nop   = 1'b1;
          end else if (dx_is_md) begin
            w_md_start   = 1'b1;
            w_md_cnt_nxt = '0;
            w_state_nxt  = ST_MD_WAIT;
          end else if (w_load_use) begin
            w_pc_we  = 1'b0;
            w_fd_we  = 1'b0;
            w_dx_nop = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          // Only the writeback latch keeps moving to drain older work.
          w_mw_we = 1'b1;
          if (r_md_cnt != '1) w_md_cnt_nxt = r_md_cnt + 1'b1;
          if (md_ready) begin
            w_state_nxt = ST_MD_DONE;
          end else if (r_md_cnt == MDC_LAST) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_MD_DONE;
          end
        end
        ST_MD_DONE: begin
          w_pc_we     = 1'b1;
          w_fd_we     = 1'b1;
          w_dx_we     = 1'b1;
          w_xm_we     = 1'b1;
          w_mw_we     = 1'b1;
          w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign pc_we     = w_pc_we;
  assign fd_we     = w_fd_we;
  assign dx_we     = w_dx_we;
  assign xm_we     = w_xm_we;
  assign mw_we     = w_mw_we;
  assign fd_flush  = w_fd_flush;
  assign dx_nop    = w_dx_nop;
  assign md_start  = w_md_start;
  assign md_err    = r_md_err;
  assign dbg_state = r_state;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_we && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_fd_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Build with PIPE_PERF_CNT_EN defined to
// also exercise the performance counters.
module tb_pipeline_hazard_ctrl;

  localparam int MD_TIMEOUT = 40;
  localparam int CNT_W      = 6;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] fd_rs = '0, fd_rt = '0, dx_rd = '0;
  logic       fd_uses_rs = 1'b0, fd_uses_rt = 1'b0;
  logic       dx_is_load = 1'b0, dx_is_md = 1'b0, md_ready = 1'b0, x_branch_taken = 1'b0;
  logic       pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_nop, md_start, md_err;
  logic [1:0] dbg_state;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .fd_rs          (fd_rs),
    .fd_rt          (fd_rt),
    .fd_uses_rs     (fd_uses_rs),
    .fd_uses_rt     (fd_uses_rt),
    .dx_rd          (dx_rd),
    .dx_is_load     (dx_is_load),
    .dx_is_md       (dx_is_md),
    .md_ready       (md_ready),
    .x_branch_taken (x_branch_taken),
    .pc_we          (pc_we),
    .fd_we          (fd_we),
    .dx_we          (dx_we),
    .xm_we          (xm_we),
    .mw_we          (mw_we),
    .fd_flush       (fd_flush),
    .dx_nop         (dx_nop),
    .md_start       (md_start),
    .md_err         (md_err),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  int checks = 0;
  int passes = 0;

  // Output vector: [8]pc [7]fd [6]dx [5]xm [4]mw [3]flush [2]nop [1]start [0]err
  logic [8:0] obs, exp_o;

  // Reference model: "busy waiting for mul/div", "one catch-up cycle",
  // number of cycles waited so far, sticky error, and perf tallies.
  bit m_wait, m_done, m_err;
  int m_waited;
  int m_stall, m_flush;
  int exp_stall, exp_flush;
  logic [CNT_W-1:0] obs_stall = '0, obs_flush = '0;

  function automatic bit ref_hazard();
    bit rs_hit, rt_hit;
    rs_hit = fd_uses_rs && (fd_rs == dx_rd);
    rt_hit = fd_uses_rt && (fd_rt == dx_rd);
    return dx_is_load && (dx_rd != 0) && (rs_hit || rt_hit);
  endfunction

  function automatic logic [8:0] ref_outputs();
    logic [8:0] e;
    if (!reset)              e = 9'b0;
    else if (m_wait)         e = {5'b00001, 3'b000, m_err};
    else if (m_done)         e = {5'b11111, 3'b000, m_err};
    else if (x_branch_taken) e = {5'b11111, 3'b110, m_err};
    else if (dx_is_md)       e = {5'b11111, 3'b001, m_err};
    else if (ref_hazard())   e = {5'b00111, 3'b010, m_err};
    else                     e = {5'b11111, 3'b000, m_err};
    return e;
  endfunction

  // One clock cycle: sample at the falling edge, advance the model, and
  // return just after the next rising edge ready for new stimulus.
  task automatic cyc();
    @(negedge clk);
    if (!reset) begin
      m_wait = 0; m_done = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end
    exp_o = ref_outputs();
    obs   = {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_nop, md_start, md_err};
    exp_stall = m_stall;
    exp_flush = m_flush;
`ifdef PIPE_PERF_CNT_EN
    obs_stall = stall_cnt;
    obs_flush = flush_cnt;
`endif
    if (reset) begin
      if (!exp_o[8] && m_stall < CNT_MAX) m_stall++;
      if (exp_o[3] && m_flush < CNT_MAX) m_flush++;
      if (m_wait) begin
        m_waited++;
        if (md_ready) begin
          m_wait = 0; m_done = 1;
        end else if (m_waited == MD_TIMEOUT) begin
          m_wait = 0; m_done = 1; m_err = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (!x_branch_taken && dx_is_md) begin
        m_wait = 1; m_waited = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fd_rs = '0; fd_rt = '0; dx_rd = '0;
    fd_uses_rs = 0; fd_uses_rt = 0;
    dx_is_load = 0; dx_is_md = 0; md_ready = 0; x_branch_taken = 0;
  endtask

  task automatic test_reset();
    // Busy inputs during reset must not leak to the outputs.
    dx_is_md = 1; x_branch_taken = 1; md_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== exp_o) $display("FAIL reset cyc%0d: got %b want %b", i, obs, exp_o);
      else passes++;
    end
    reset = 1;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (obs !== exp_o) $display("FAIL post_reset cyc%0d: got %b want %b", i, obs, exp_o);
      else passes++;
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    dx_is_load = 1; dx_rd = 5; fd_rs = 5; fd_uses_rs = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== exp_o) $display("FAIL load_use cyc%0d: got %b want %b", i, obs, exp_o);
      else passes++;
      // DX now holds the injected nop, so the hazard is gone.
      dx_is_load = 0;
    end
    // rt-side match
    dx_is_load = 1; dx_rd = 9; fd_rt = 9; fd_uses_rt = 1; fd_uses_rs = 0;
    cyc();
    checks++;
    if (obs[8:2] !== 7'b0011101) $display("FAIL load_use_rt: got %b want %b", obs[8:2], 7'b0011101);
    else passes++;
    clear_inputs();
  endtask

  task automatic test_r0_exempt();
    clear_inputs();
    dx_is_load = 1; dx_rd = 0; fd_rs = 0; fd_uses_rs = 1;
    cyc();
    checks++;
    if (obs !== exp_o || obs[8:2] !== 7'b1111100)
      $display("FAIL r0_exempt: got %b want %b", obs, exp_o);
    else passes++;
    // matching register that is not read does not stall either
    dx_rd = 7; fd_rs = 7; fd_uses_rs = 0;
    cyc();
    checks++;
    if (obs !== exp_o) $display("FAIL unused_src: got %b want %b", obs, exp_o);
    else passes++;
    clear_inputs();
  endtask

  task automatic test_priority();
    clear_inputs();
    x_branch_taken = 1; dx_is_load = 1; dx_rd = 5; fd_rs = 5; fd_uses_rs = 1;
    cyc();
    checks++;
    if (obs !== exp_o || obs[8] !== 1'b1 || obs[3:2] !== 2'b11)
      $display("FAIL priority: got %b want %b", obs, exp_o);
    else passes++;
    clear_inputs();
  endtask

  task automatic test_multdiv(input int ready_at);
    int stalls, starts;
    clear_inputs();
    dx_is_md = 1; md_ready = 1;   // ready alongside start is ignored
    cyc();
    checks++;
    if (obs !== exp_o) $display("FAIL md_start: got %b want %b", obs, exp_o);
    else passes++;
    stalls = 0; starts = 0;
    dx_is_md = 0;
    for (int i = 0; i < ready_at + 2; i++) begin
      md_ready = (i == ready_at - 1);
      cyc();
      checks++;
      if (obs !== exp_o) $display("FAIL md_seq cyc%0d: got %b want %b", i, obs, exp_o);
      else passes++;
      if (!obs[8]) stalls++;
      if (obs[1]) starts++;
    end
    checks++;
    if (stalls !== ready_at || starts !== 0)
      $display("FAIL md_stall_len: got %0d stalls %0d restarts want %0d stalls 0 restarts",
               stalls, starts, ready_at);
    else passes++;
    clear_inputs();
  endtask

  task automatic test_timeout();
    int stalls;
    clear_inputs();
    dx_is_md = 1;
    cyc();
    dx_is_md = 0;
    stalls = 0;
    for (int i = 0; i < MD_TIMEOUT + 6; i++) begin
      cyc();
      checks++;
      if (obs !== exp_o) $display("FAIL timeout cyc%0d: got %b want %b", i, obs, exp_o);
      else passes++;
      if (!obs[8]) stalls++;
    end
    checks++;
    if (stalls !== MD_TIMEOUT || obs[0] !== 1'b1)
      $display("FAIL timeout_len: got %0d stalls err=%b want %0d stalls err=1",
               stalls, obs[0], MD_TIMEOUT);
    else passes++;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    dx_is_md = 1;
    cyc();
    dx_is_md = 0;
    for (int i = 0; i < 10; i++) cyc();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (obs !== 9'b0) $display("FAIL reset_mid cyc%0d: got %b want %b", i, obs, 9'b0);
      else passes++;
    end
    reset = 1;
    cyc();
    checks++;
    if (obs !== exp_o || obs !== 9'b111110000)
      $display("FAIL after_reset_mid: got %b want %b", obs, 9'b111110000);
    else passes++;
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (obs_stall !== '0) $display("FAIL stall_cnt_after_reset: got %0d want 0", obs_stall);
    else passes++;
`endif
  endtask

  task automatic test_random(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) begin
      fd_rs      = 5'($urandom_range(0, 3));
      fd_rt      = 5'($urandom_range(0, 3));
      dx_rd      = 5'($urandom_range(0, 3));
      fd_uses_rs = 1'($urandom_range(0, 1));
      fd_uses_rt = 1'($urandom_range(0, 1));
      dx_is_load = ($urandom_range(0, 2) == 0);
      dx_is_md   = !dx_is_load && ($urandom_range(0, 15) == 0);
      md_ready   = ($urandom_range(0, 7) == 0);
      x_branch_taken = !(m_wait || m_done) && ($urandom_range(0, 5) == 0);
      cyc();
      checks++;
      if (obs !== exp_o) $display("FAIL random cyc%0d: got %b want %b", i, obs, exp_o);
      else passes++;
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (obs_stall !== CNT_W'(exp_stall) || obs_flush !== CNT_W'(exp_flush))
        $display("FAIL random_perf cyc%0d: got %0d/%0d want %0d/%0d",
                 i, obs_stall, obs_flush, exp_stall, exp_flush);
      else passes++;
`endif
    end
    clear_inputs();
  endtask

  task automatic test_perf_saturation();
`ifdef PIPE_PERF_CNT_EN
    clear_inputs();
    x_branch_taken = 1;
    for (int i = 0; i < CNT_MAX + 8; i++) cyc();
    x_branch_taken = 0;
    for (int r = 0; r < 2; r++) begin
      dx_is_md = 1;
      cyc();
      dx_is_md = 0;
      for (int i = 0; i < MD_TIMEOUT + 2; i++) cyc();
    end
    cyc();
    checks++;
    if (obs_stall !== CNT_W'(CNT_MAX) || obs_flush !== CNT_W'(CNT_MAX) ||
        obs_stall !== CNT_W'(exp_stall) || obs_flush !== CNT_W'(exp_flush))
      $display("FAIL perf_saturate: got %0d/%0d want %0d/%0d",
               obs_stall, obs_flush, CNT_MAX, CNT_MAX);
    else passes++;
`endif
  endtask

  initial begin
    m_wait = 0; m_done = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    test_reset();
    test_load_use();
    test_r0_exempt();
    test_priority();
    test_multdiv(32);
    test_multdiv(1);
    test_timeout();
    test_load_use();
    test_reset_mid();
    test_random(600);
    test_perf_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 40, the maximum number of MD_WAIT cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the performance counters.
REQ-003 clk  in  1  single clock; the controller state updates on the rising edge, and the pipeline latches sample on the falling edge.
REQ-004 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-005 fd_rs, fd_rt  in  5 each  source registers of the instruction in FD.
REQ-006 fd_uses_rs, fd_uses_rt  in  1 each  the corresponding source is actually read.
REQ-007 dx_rd  in  5  destination of the instruction in DX; dx_is_load  in  1  that instruction is lw.
REQ-008 dx_is_md  in  1  the DX instruction is mul/div; md_ready  in  1  the multdiv unit result is valid.
REQ-009 x_branch_taken  in  1  a taken branch or jump is resolved in X this cycle.
REQ-010 pc_we, fd_we, dx_we, xm_we, mw_we  out  1 each  write enables for PC and the four pipeline latches.
REQ-011 fd_flush, dx_nop  out  1 each  load a nop into FD or DX instead of captured data.
REQ-012 md_start  out  1  one-cycle start pulse to the multdiv unit; md_err  out  1  sticky timeout flag.
REQ-013 stall_cnt, flush_cnt  out  CNT_W each  present only when PIPE_PERF_CNT_EN is defined.

Function
REQ-014 SHALL implement FSM states RUN, MD_WAIT and MD_DONE, encoded in 2 bits.
REQ-015 RUN, default: all write enables are 1; fd_flush, dx_nop and md_start are 0.
REQ-016 A load-use hazard is dx_is_load & dx_rd!=0 & ((fd_uses_rs & fd_rs==dx_rd) | (fd_uses_rt & fd_rt==dx_rd)).
REQ-017 RUN with a load-use hazard: pc_we=0, fd_we=0, dx_nop=1 for exactly one cycle; the state remains RUN.
REQ-018 RUN with x_branch_taken: fd_flush=1 and dx_nop=1, with PC advancing; this takes priority over a load-use hazard in the same cycle.
REQ-019 RUN with dx_is_md and no branch: md_start=1 for one cycle and the state moves to MD_WAIT; the cycle counter clears to 0.
REQ-020 MD_WAIT: pc_we, fd_we, dx_we and xm_we are 0; mw_we is 1; dx_nop is 0; the counter increments each cycle.
REQ-021 MD_WAIT with md_ready moves to MD_DONE; md_ready in the same cycle as md_start is ignored.
REQ-022 MD_WAIT with counter==MD_TIMEOUT-1 and no md_ready: md_err is set (sticky), and the state moves to MD_DONE.
REQ-023 MD_DONE: all write enables are 1 for one cycle so XM captures the result; next state RUN; hazards are not evaluated in MD_DONE.
REQ-024 md_ready in RUN SHALL be ignored.
REQ-025 The counter SHALL be ceil(log2(MD_TIMEOUT+1)) bits wide and saturate, never wrapping.

Reset
REQ-026 While reset=0: state RUN, counter 0, md_err 0, all write enables 0, fd_flush, dx_nop and md_start 0, counters 0.
REQ-027 Reset asserted in MD_WAIT SHALL abort immediately with no md_start re-issue; the first cycle after release is RUN.

Configuration
REQ-028 With PIPE_PERF_CNT_EN defined: stall_cnt increments on each cycle with pc_we=0, and flush_cnt increments on each cycle with fd_flush=1.
REQ-029 Both counters SHALL saturate at all-ones.
REQ-030 Without PIPE_PERF_CNT_EN: the counter ports and logic are absent, and behaviour is otherwise identical.

Structure
REQ-031 The state enum, the RUN/MD_WAIT/MD_DONE encodings, the nop instruction constant (32'h0) and the register-0 index SHALL live in the shared package pipe_pkg.
REQ-032 The hazard comparator is natural as sub-module load_use_detect (purely combinational); the FSM and counters stay in the top level.

Verification
REQ-033 Load-use: dx_is_load=1, dx_rd=5, fd_rs=5, fd_uses_rs=1 -> one cycle of pc_we=0, fd_we=0, dx_nop=1, then 1/1/0.
REQ-034 r0 exemption: same stimulus as REQ-033 with dx_rd=0 and fd_rs=0 -> no stall.
REQ-035 Multdiv: dx_is_md=1, md_ready after 32 cycles -> md_start pulses once, then 32 cycles of pc_we=0 with mw_we=1, then one MD_DONE cycle with all enables 1, then RUN.
REQ-036 Timeout: dx_is_md=1, md_ready held 0 -> md_err=1 after 40 cycles in MD_WAIT; md_err remains 1 until reset=0.
REQ-037 Priority: x_branch_taken=1 together with a load-use match -> fd_flush=1, dx_nop=1, pc_we=1.
REQ-038 Reset mid-operation: reset=0 at cycle 10 of MD_WAIT -> all outputs 0 immediately; after release, RUN with md_err=0; with PIPE_PERF_CNT_EN, stall_cnt=0.
